// File: rtl/noc_vc_port_allocator_pkg.sv
// rtl/noc_vc_port_allocator_pkg.sv - shared types and width helpers for the VC/port allocator
package noc_vc_port_allocator_pkg;

  localparam int NOC_VC_CHANNEL = 2;
  localparam int NOC_INPORTS    = 5;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_LOCKED = 1'b1
  } vc_state_e;

  typedef logic [NOC_INPORTS-1:0] route_vec_t;

  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// rtl/noc_credit_counter.sv - per-VC saturating downstream credit counter
module noc_credit_counter #(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != CW'(CREDITS)) cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0)      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CW'(CREDITS);
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc_i && !dec_i && cnt_q == CW'(CREDITS))) else $error("noc_credit_counter: overflow");
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec_i && !inc_i && cnt_q == '0)) else $error("noc_credit_counter: underflow");

endmodule

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - small circular FIFO; head reads as zero while empty
module noc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CNTW-1:0] cnt_q;
  logic            do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o))
    else $error("noc_fifo: pop while empty");

endmodule

// File: rtl/noc_round_robin_arbiter.sv
// rtl/noc_round_robin_arbiter.sv - combinational round-robin pick starting at an external pointer
module noc_round_robin_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          valid_o
);

  always_comb begin
    int idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!valid_o && req_i[idx]) begin
        valid_o    = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_vc_port_allocator.sv
// rtl/noc_vc_port_allocator.sv - per-VC packet lock, per-port VC arbitration and credit-gated flit grant
module noc_vc_port_allocator
  import noc_vc_port_allocator_pkg::*;
#(
  parameter int INPORTS     = 5,
  parameter int CHANNELS    = NOC_VC_CHANNEL,
  parameter int CREDITS     = 4,
  parameter int ROUTE_DEPTH = 2,
  parameter int CW          = credit_width(CREDITS)
) (
  input  logic                              noc_clk,
  input  logic                              noc_rst_n,
  input  logic [INPORTS-1:0][CHANNELS-1:0]  req_i,
  input  logic [INPORTS-1:0][CHANNELS-1:0]  eop_i,
  input  logic [CHANNELS-1:0]               credit_i,
  input  logic [CHANNELS-1:0]               route_pop_i,
  output logic [INPORTS-1:0][CHANNELS-1:0]  grant_o,
  output logic [CHANNELS-1:0][INPORTS-1:0]  route_o,
  output logic [CHANNELS-1:0]               route_valid_o,
  output logic [CHANNELS-1:0][CW-1:0]       credit_cnt_o
);

  localparam int PW = idx_width(INPORTS);
  localparam int VW = idx_width(CHANNELS);

  vc_state_e     state_q [CHANNELS];
  vc_state_e     state_d [CHANNELS];
  logic [PW-1:0] owner_q [CHANNELS];
  logic [PW-1:0] owner_d [CHANNELS];
  logic [PW-1:0] ptr_q   [CHANNELS];
  logic [PW-1:0] ptr_d   [CHANNELS];
  logic [VW-1:0] vc_ptr_q [INPORTS];
  logic [VW-1:0] vc_ptr_d [INPORTS];

  logic [CHANNELS-1:0][INPORTS-1:0] req_t, lock_gnt;
  logic [PW-1:0]                    lock_idx [CHANNELS];
  logic [CHANNELS-1:0]              lock_valid, lock_fire, release_vc, dec, fifo_full, fifo_empty;
  logic [INPORTS-1:0][CHANNELS-1:0] eligible;
  logic [VW-1:0]                    vc_gnt_idx [INPORTS];
  logic [INPORTS-1:0]               vc_gnt_valid;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
    for (genvar p = 0; p < INPORTS; p++) begin : g_col
      assign req_t[c][p] = req_i[p][c];
    end

    noc_round_robin_arbiter #(.N(INPORTS), .IW(PW)) u_lock_arb (
      .req_i(req_t[c]), .ptr_i(ptr_q[c]),
      .gnt_o(lock_gnt[c]), .gnt_idx_o(lock_idx[c]), .valid_o(lock_valid[c])
    );

    // A lock needs a free route slot so the winner is always recorded.
    assign lock_fire[c] = (state_q[c] == VC_IDLE) && lock_valid[c] && !fifo_full[c];

    noc_fifo #(.W(INPORTS), .DEPTH(ROUTE_DEPTH)) u_route_fifo (
      .clk(noc_clk), .rst_n(noc_rst_n),
      .push_i(lock_fire[c]), .wdata_i(lock_gnt[c]), .pop_i(route_pop_i[c]),
      .rdata_o(route_o[c]), .empty_o(fifo_empty[c]), .full_o(fifo_full[c])
    );

    noc_credit_counter #(.CREDITS(CREDITS), .CW(CW)) u_credit (
      .clk(noc_clk), .rst_n(noc_rst_n),
      .inc_i(credit_i[c]), .dec_i(dec[c]), .cnt_o(credit_cnt_o[c])
    );
  end

  assign route_valid_o = ~fifo_empty;

  always_comb begin
    eligible = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int p = 0; p < INPORTS; p++) begin
        eligible[p][c] = (state_q[c] == VC_LOCKED) && (owner_q[c] == PW'(p)) &&
                         req_i[p][c] && (credit_cnt_o[c] != '0);
      end
    end
  end

  for (genvar p = 0; p < INPORTS; p++) begin : g_port
    noc_round_robin_arbiter #(.N(CHANNELS), .IW(VW)) u_vc_arb (
      .req_i(eligible[p]), .ptr_i(vc_ptr_q[p]),
      .gnt_o(grant_o[p]), .gnt_idx_o(vc_gnt_idx[p]), .valid_o(vc_gnt_valid[p])
    );
  end

  always_comb begin
    dec        = '0;
    release_vc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int p = 0; p < INPORTS; p++) begin
        if (grant_o[p][c]) begin
          dec[c] = 1'b1;
          if (eop_i[p][c]) release_vc[c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      owner_d[c] = owner_q[c];
      ptr_d[c]   = ptr_q[c];
      case (state_q[c])
        VC_IDLE: begin
          if (lock_fire[c]) begin
            state_d[c] = VC_LOCKED;
            owner_d[c] = lock_idx[c];
          end
        end
        VC_LOCKED: begin
          if (release_vc[c]) begin
            state_d[c] = VC_IDLE;
            ptr_d[c]   = (owner_q[c] == PW'(INPORTS - 1)) ? '0 : owner_q[c] + 1'b1;
          end
        end
        default: state_d[c] = VC_IDLE;
      endcase
    end
    for (int p = 0; p < INPORTS; p++) begin
      vc_ptr_d[p] = vc_ptr_q[p];
      if (vc_gnt_valid[p])
        vc_ptr_d[p] = (vc_gnt_idx[p] == VW'(CHANNELS - 1)) ? '0 : vc_gnt_idx[p] + 1'b1;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= VC_IDLE;
        owner_q[c] <= '0;
        ptr_q[c]   <= '0;
      end
      for (int p = 0; p < INPORTS; p++) vc_ptr_q[p] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        owner_q[c] <= owner_d[c];
        ptr_q[c]   <= ptr_d[c];
      end
      for (int p = 0; p < INPORTS; p++) vc_ptr_q[p] <= vc_ptr_d[p];
    end
  end

endmodule

// File: tb/tb_noc_vc_port_allocator.sv
// tb/tb_noc_vc_port_allocator.sv - directed self-checking bench for noc_vc_port_allocator
module tb_noc_vc_port_allocator;

  localparam int INP = 5, CH = 2, CRED = 4, DEPTH = 2, CW = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [INP-1:0][CH-1:0]   req, eop, grant;
  logic [CH-1:0]            credit, pop, rvalid;
  logic [CH-1:0][INP-1:0]   route;
  logic [CH-1:0][CW-1:0]    ccnt;
  int                       checks = 0;
  int                       failures = 0;

  always #5 clk = ~clk;

  noc_vc_port_allocator #(
    .INPORTS(INP), .CHANNELS(CH), .CREDITS(CRED), .ROUTE_DEPTH(DEPTH), .CW(CW)
  ) dut (
    .noc_clk(clk), .noc_rst_n(rst_n),
    .req_i(req), .eop_i(eop), .credit_i(credit), .route_pop_i(pop),
    .grant_o(grant), .route_o(route), .route_valid_o(rvalid), .credit_cnt_o(ccnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gbit(input int p, input int c);
    logic [31:0] one;
    one = 32'd1;
    return one << (p * CH + c);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    eop    = '0;
    credit = '0;
    pop    = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    eop    = '0;
    credit = '0;
    pop    = '0;
    cyc();
    settle();
    check_eq("rst_credit", ccnt, {3'd4, 3'd4});
    check_eq("rst_grant", grant, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_route", route, 0);

    // single 3-flit packet, port 2 on VC0
    do_reset();
    req[2][0] = 1'b1;
    settle();
    check_eq("t1_lock_nogrant", grant, 0);
    check_eq("t1_rvalid_pre", rvalid, 0);
    cyc(); settle();
    check_eq("t1_route", route[0], 5'b00100);
    check_eq("t1_g1", grant, gbit(2, 0));
    cyc(); settle();
    check_eq("t1_g2", grant, gbit(2, 0));
    cyc(); eop[2][0] = 1'b1; settle();
    check_eq("t1_g3", grant, gbit(2, 0));
    check_eq("t1_cred_mid", ccnt[0], 2);
    cyc(); req = '0; eop = '0; settle();
    check_eq("t1_cred_end", ccnt[0], 1);
    check_eq("t1_idle_grant", grant, 0);
    check_eq("t1_rvalid", rvalid, 2'b01);
    req[2][0] = 1'b1; settle();
    check_eq("t1_relock_nogrant", grant, 0);
    cyc(); settle();
    check_eq("t1_relock_grant", grant, gbit(2, 0));

    // contention on VC0 between ports 1 and 3
    do_reset();
    req[1][0] = 1'b1; req[3][0] = 1'b1; settle();
    check_eq("t2_lock_nogrant", grant, 0);
    cyc(); eop[1][0] = 1'b1; settle();
    check_eq("t2_p1_wins", grant, gbit(1, 0));
    check_eq("t2_route_p1", route[0], 5'b00010);
    cyc(); req[1][0] = 1'b0; eop[1][0] = 1'b0; settle();
    check_eq("t2_relock_nogrant", grant, 0);
    cyc(); eop[3][0] = 1'b1; pop[0] = 1'b1; settle();
    check_eq("t2_p3_grant", grant, gbit(3, 0));
    check_eq("t2_head_still_p1", route[0], 5'b00010);
    cyc(); req = '0; eop = '0; pop = '0; settle();
    check_eq("t2_route_p3", route[0], 5'b01000);
    check_eq("t2_cred", ccnt[0], 2);

    // credit stall, port 0 on VC1
    do_reset();
    req[0][1] = 1'b1; settle();
    check_eq("t3_lock_nogrant", grant, 0);
    for (int i = 0; i < CRED; i++) begin
      cyc(); settle();
      check_eq($sformatf("t3_flit%0d", i), grant, gbit(0, 1));
    end
    cyc(); settle();
    check_eq("t3_stall", grant, 0);
    check_eq("t3_cred_zero", ccnt[1], 0);
    cyc(); credit[1] = 1'b1; settle();
    check_eq("t3_no_bypass", grant, 0);
    cyc(); credit[1] = 1'b0; eop[0][1] = 1'b1; settle();
    check_eq("t3_after_credit", grant, gbit(0, 1));
    check_eq("t3_cred_one", ccnt[1], 1);
    cyc(); req = '0; eop = '0; settle();
    check_eq("t3_cred_final", ccnt, {3'd0, 3'd4});

    // one port locked on both VCs: grants alternate
    do_reset();
    req[4][0] = 1'b1; req[4][1] = 1'b1; settle();
    check_eq("t4_lock_nogrant", grant, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      check_eq($sformatf("t4_alt%0d", i), grant, gbit(4, i % 2));
    end
    cyc(); req = '0; settle();
    check_eq("t4_cred", ccnt, {3'd2, 3'd2});
    check_eq("t4_route1", route[1], 5'b10000);

    // route FIFO full blocks the third lock until a pop
    do_reset();
    req[0][0] = 1'b1; eop[0][0] = 1'b1; settle();
    check_eq("t5_lock1", grant, 0);
    cyc(); settle();
    check_eq("t5_pkt1", grant, gbit(0, 0));
    cyc(); settle();
    check_eq("t5_lock2", grant, 0);
    cyc(); settle();
    check_eq("t5_pkt2", grant, gbit(0, 0));
    cyc(); settle();
    check_eq("t5_blocked_a", grant, 0);
    cyc(); settle();
    check_eq("t5_blocked_b", grant, 0);
    check_eq("t5_rvalid", rvalid[0], 1);
    pop[0] = 1'b1;
    cyc(); pop[0] = 1'b0; settle();
    check_eq("t5_lock3", grant, 0);
    check_eq("t5_head", route[0], 5'b00001);
    cyc(); settle();
    check_eq("t5_pkt3", grant, gbit(0, 0));
    check_eq("t5_cred_mid", ccnt[0], 2);
    cyc(); req = '0; eop = '0; settle();
    check_eq("t5_cred_end", ccnt[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_vc_port_allocator.md
Name: noc_vc_port_allocator

Overview:
- Parametrised successor to the router's local-port control.
- For each output virtual channel (VC), allocates an output port among INPORTS input ports and holds the allocation for a whole packet.
- Arbitrates per input port among its allocated VCs each cycle, and gates every flit grant on downstream credit.
- Records each packet's winning input port in a per-VC route FIFO of configurable depth, which the crossbar/output stage reads to steer flits.

Parameters:
- INPORTS, 5: number of input ports competing for this output port (≥2).
- CHANNELS, Noc_VC_Channel: number of VCs (≥1).
- CREDITS, 4: downstream buffer depth per VC; reset value of each credit counter.
- ROUTE_DEPTH, 2: entries per VC route FIFO (≥1).
- CW, $clog2(CREDITS+1): credit counter width (derived).

Ports:
- noc_clk  in  1  router clock.
- noc_rst_n  in  1  asynchronous active-low reset.
- req_i  in  [INPORTS][CHANNELS]  input p has a packet head waiting for VC c.
- eop_i  in  [INPORTS][CHANNELS]  flit offered by p on VC c is the tail; qualified only with the matching grant_o.
- credit_i  in  [CHANNELS]  one credit returned from downstream for VC c.
- route_pop_i  in  [CHANNELS]  output stage consumes the head route entry of VC c.
- grant_o  out  [INPORTS][CHANNELS]  flit transfer from p on VC c this cycle.
- route_o  out  [CHANNELS][INPORTS]  one-hot head route entry per VC.
- route_valid_o  out  [CHANNELS]  route FIFO of VC c is non-empty.
- credit_cnt_o  out  [CHANNELS][CW]  current credit count per VC.

Behaviour:
- Reset (asynchronous, noc_rst_n low):
  - all VCs go to IDLE and all round-robin pointers go to 0;
  - credit counters load CREDITS and route FIFOs empty;
  - grant_o=0, route_valid_o=0, route_o=0, credit_cnt_o=CREDITS.
- A reset mid-packet abandons the lock with no recovery.
- Per-VC state machine, IDLE / LOCKED(owner):
  - IDLE→LOCKED when any req_i[*][c] is set and the route FIFO of c is not full. The winner is the round-robin choice starting at ptr[c].
  - On that edge, the winner's one-hot is pushed into route FIFO c, so the entry is visible at route_o the next cycle.
  - With the FIFO full, the VC stays IDLE and no push occurs.
  - LOCKED→IDLE at the edge where grant_o[owner][c] and eop_i[owner][c] are both high. ptr[c] is then set to owner+1, wrapping to 0 after INPORTS-1.
- Flit grant (combinational from registered state):
  - VC c is eligible at port p iff LOCKED, owner==p, req_i[p][c] is high, and credit_cnt[c] > 0.
  - Each port runs its own round-robin over its eligible VCs, so at most one grant per port per cycle.
  - That VC pointer advances past the granted VC after each grant.
  - No grant in the lock cycle itself: first grant at earliest 1 cycle after req_i.
- Credits:
  - decrement when any grant_o[*][c] is high; increment on credit_i[c]; both in the same cycle leaves the count unchanged;
  - a credit returned in cycle t enables a grant in t+1 at the earliest (no combinational bypass);
  - increment at CREDITS and decrement at 0 are illegal: assertion fires and the count saturates.
- Route FIFO:
  - route_pop_i on an empty FIFO is ignored (assertion);
  - simultaneous push and pop when full is not allowed, because the lock requires not-full.
- Single-packet lock: the same input may re-win immediately only if no other port requests.

Decomposition:
- Add to Noc_parameters:
  - credit width helper;
  - typedef for the per-VC state enum (IDLE/LOCKED);
  - typedef for a one-hot INPORTS route vector.
- Reuse Noc_round_robin_arbiter for both arbitration levels. The port arbiter uses KEEP_RESULT=0 with the lock held externally.
- Reuse Noc_fifo for the route FIFO.
- Add one new sub-module, noc_credit_counter: per-VC up/down saturating counter with assertions.

Test Plan:
- Reset → CREDITS=4, CHANNELS=2: credit_cnt_o={4,4}, grant_o=0, route_valid_o=0.
- Single packet: req_i[2][0]=1, 3-flit packet, eop on the 3rd flit → route_o[0]=5'b00100 one cycle after req, grant_o[2][0] high 3 cycles, credit_cnt_o[0]=1, then IDLE.
- Contention: ports 1 and 3 request VC0 simultaneously with ptr=0 → port 1 wins. After its eop, port 3 wins with no idle cycle between lock release and next lock.
- Credit stall: CREDITS=2, 4-flit packet, no credit_i → grants stop after 2 flits. credit_i pulse at cycle t → one grant at t+1.
- Same port on VC0 and VC1, both locked with credit → grants alternate VC0/VC1 each cycle; never two grants for one port in one cycle.
- Route FIFO full: ROUTE_DEPTH=2, three short packets, no route_pop_i → third lock blocked. route_pop_i → third lock next cycle.
